// File: rtl/pipe_reg_chain.sv
// Elastic register chain with bubble-collapsing ready propagation.
// Stage DEPTH-1 drives q/out_valid directly from flops; count is next-state occupancy.

module pipe_reg_chain_stage #(
  parameter int WIDTH = 26,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rdy,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             v_nxt,
  output logic             v,
  output logic [WIDTH-1:0] r
);
  always_comb begin
    v_nxt = v;
    if (rst || flush) v_nxt = 1'b0;
    else if (rdy)     v_nxt = up_valid;
  end

  // Data only moves on a real transfer, so r holds across flush and bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      r <= RESET_VAL;
    end else begin
      v <= v_nxt;
      if (rdy && up_valid && !flush) r <= up_data;
    end
  end
endmodule

module pipe_reg_chain #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0]            v, v_nxt, rdy, up_v;
  logic [DEPTH-1:0][WIDTH-1:0] r, up_d;
  logic [CW-1:0]               cnt_nxt;

  always_comb begin
    rdy[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) rdy[i] = rdy[i+1] | ~v[i];
    up_v[0] = in_valid;
    up_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = r[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    pipe_reg_chain_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stg (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rdy      (rdy[g]),
      .up_valid (up_v[g]),
      .up_data  (up_d[g]),
      .v_nxt    (v_nxt[g]),
      .v        (v[g]),
      .r        (r[g])
    );
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= cnt_nxt;
  end

  assign in_ready  = rdy[0] & ~flush & ~rst;
  assign q         = r[DEPTH-1];
  assign out_valid = v[DEPTH-1];
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed + randomized bench for pipe_reg_chain (WIDTH=26, DEPTH=3) with an order scoreboard.
module tb_pipe_reg_chain;
  localparam int W = 26;
  localparam int D = 3;
  localparam logic [W-1:0] RV = 26'h0ABCDE;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready, in_ready, out_valid;
  logic [W-1:0] d, q;
  logic [1:0]   count;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb[$];
  logic ir_s;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .d(d),
    .in_ready(in_ready), .q(q), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, sample transfers before the edge, update scoreboard, check occupancy after.
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy,
                     input logic fl, input logic rs);
    logic acc, del;
    logic [W-1:0] qs, e;
    in_valid = iv; d = id; out_ready = ordy; flush = fl; rst = rs;
    #1;
    ir_s = in_ready;
    acc = in_valid & in_ready;
    del = out_valid & out_ready;
    qs = q;
    @(posedge clk); #1;
    if (rs) sb.delete();
    else begin
      if (del) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(qs), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("sb_order", 32'(qs), 32'(e));
        end
      end
      if (fl) sb.delete();
      else if (acc) sb.push_back(id);
    end
    chk("count_occ", 32'(count), 32'(sb.size()));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;

    // Reset state
    cyc(1'b1, 26'h1, 1'b1, 1'b0, 1'b1);
    chk("rst_inready", 32'(ir_s), 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_outvalid", 32'(out_valid), 0);
    chk("rst_q", 32'(q), 32'(RV));
    chk("rst_count", 32'(count), 0);

    // Streaming: latency of 3 edges, continuous out_valid
    for (int i = 0; i < 8; i++) begin
      cyc(i < 5, W'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i == 0) chk("first_acc_inready", 32'(ir_s), 1);
      if (i >= 2 && i < 7) begin
        chk("stream_q", 32'(q), 32'(i - 1));
        chk("stream_ov", 32'(out_valid), 1);
      end
    end
    chk("stream_empty_ov", 32'(out_valid), 0);

    // Backpressure fill, then full-chain pass-through
    cyc(1'b1, 26'h3FFFFFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h3FFFFFE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h3FFFFFD, 1'b0, 1'b0, 1'b0);
    chk("fill_inready3", 32'(ir_s), 1);
    cyc(1'b1, 26'h3FFFFFC, 1'b0, 1'b0, 1'b0);
    chk("full_inready", 32'(ir_s), 0);
    chk("full_count", 32'(count), 3);
    chk("full_hold_q", 32'(q), 32'h3FFFFFF);
    cyc(1'b1, 26'h3FFFFFC, 1'b1, 1'b0, 1'b0);
    chk("full_pass_inready", 32'(ir_s), 1);
    chk("drain_q0", 32'(q), 32'h3FFFFFE);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_q1", 32'(q), 32'h3FFFFFD);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_q2", 32'(q), 32'h3FFFFFC);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_count", 32'(count), 0);

    // Bubble collapse
    cyc(1'b1, 26'h1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h3, 1'b0, 1'b0, 1'b0);
    chk("bubble_inready", 32'(ir_s), 1);
    chk("bubble_count", 32'(count), 3);
    chk("bubble_q0", 32'(q), 1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bubble_q1", 32'(q), 2);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bubble_q2", 32'(q), 3);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush on a full chain with a competing input
    cyc(1'b1, 26'h111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h222, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h333, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'hABC, 1'b0, 1'b1, 1'b0);
    chk("flush_inready", 32'(ir_s), 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_ov", 32'(out_valid), 0);
    chk("flush_q_hold", 32'(q), 32'h111);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_never_out", 32'(out_valid), 0);

    // Reset beats flush with entries in flight; accept right after
    cyc(1'b1, 26'h444, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h555, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 26'h666, 1'b1, 1'b1, 1'b1);
    chk("rstmid_ov", 32'(out_valid), 0);
    chk("rstmid_q", 32'(q), 32'(RV));
    chk("rstmid_count", 32'(count), 0);
    cyc(1'b1, 26'h77, 1'b0, 1'b0, 1'b0);
    chk("postrst_inready", 32'(ir_s), 1);
    chk("postrst_count", 32'(count), 1);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 70, W'($urandom), $urandom_range(99) < 60,
          $urandom_range(99) < 3, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("final_empty", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
